line_window_align: RTL and testbench

LINE_WINDOW_ALIGN -- requirements
Module: line_window_align

---
 rtl/line_window_align_pkg.sv | 27 ++
 rtl/line_mem.sv | 27 ++
 rtl/line_window_align.sv | 155 +++++++++++++++
 tb/tb_line_window_align.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_window_align_pkg.sv
// Shared definitions for the line-buffer blocks:
// top-border mode encodings and a bit-width helper.
package line_window_align_pkg;

    typedef enum logic [1:0] {
        MODE_SUPPRESS  = 2'd0,
        MODE_ZERO      = 2'd1,
        MODE_REPLICATE = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    // Bits needed to hold the value itself (clogb2(16) = 5).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/line_mem.sv
// Single-clock line memory: combinational read of the addressed word,
// write on the clock edge, so a same-cycle read returns the old value.
module line_mem
    import line_window_align_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
)(
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_window_align.sv
// Vertical column-window builder: shifts each pixel through LINE_NUM-1
// line memories and emits one LINE_NUM-tall column per accepted pixel.
module line_window_align
    import line_window_align_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int LINE_NUM   = 3,
    parameter int MAX_WIDTH  = 256,
    localparam int WB        = clogb2(MAX_WIDTH)
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WB-1:0]                  cfg_width,
    input  logic [1:0]                     cfg_mode,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    input  logic                           in_sof,
    output logic                           in_ready,
    output logic [DATA_WIDTH*LINE_NUM-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic                           window_full
);

    localparam int RB = clogb2(LINE_NUM - 1);
    localparam int AW = (clogb2(MAX_WIDTH - 1) > 0) ? clogb2(MAX_WIDTH - 1) : 1;
    localparam logic [WB-1:0] MAXW = WB'(MAX_WIDTH);
    localparam logic [RB-1:0] LAST_ROW = RB'(LINE_NUM - 1);

    function automatic logic [WB-1:0] clamp_w(input logic [WB-1:0] w);
        if (w == '0 || w > MAXW) begin
            return MAXW;
        end
        return w;
    endfunction

    logic [WB-1:0] width_q;
    logic [WB-1:0] col;
    logic [WB-1:0] cur_width;
    logic [WB-1:0] cur_col;
    logic [WB-1:0] col_nxt;
    logic [RB-1:0] row;
    logic [RB-1:0] cur_row;
    logic [RB-1:0] row_nxt;
    mode_e         mode_q;
    mode_e         cur_mode;
    logic          sof_pend;
    logic          accept;
    logic          emit;
    logic          eol;

    logic [DATA_WIDTH-1:0] rd  [LINE_NUM-1];
    logic [DATA_WIDTH-1:0] wd  [LINE_NUM-1];
    logic [DATA_WIDTH-1:0] raw [LINE_NUM];
    logic [DATA_WIDTH-1:0] ref_pix;
    logic [DATA_WIDTH*LINE_NUM-1:0] lanes;

    assign in_ready    = ~rst & (~out_valid | out_ready);
    assign accept      = in_valid & in_ready;
    assign window_full = (row == LAST_ROW);

    // An accepted sof takes effect on its own pixel, not the next one.
    always_comb begin
        cur_width = in_sof ? clamp_w(cfg_width) : width_q;
        cur_mode  = in_sof ? mode_e'(cfg_mode) : mode_q;
        cur_col   = in_sof ? '0 : col;
        cur_row   = in_sof ? '0 : row;
        eol       = (cur_col == cur_width - WB'(1));
        if (eol) begin
            col_nxt = '0;
            row_nxt = (cur_row == LAST_ROW) ? LAST_ROW : cur_row + RB'(1);
        end else begin
            col_nxt = cur_col + WB'(1);
            row_nxt = cur_row;
        end
        emit = (cur_row == LAST_ROW)
             || (cur_mode == MODE_ZERO)
             || (cur_mode == MODE_REPLICATE);
    end

    for (genvar k = 0; k < LINE_NUM - 1; k++) begin : g_row
        if (k == 0) begin : g_first
            assign wd[k] = in_data;
        end else begin : g_next
            assign wd[k] = rd[k-1];
        end
        line_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_WIDTH),
            .AW         (AW)
        ) u_mem (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_col[AW-1:0]),
            .wdata (wd[k]),
            .rdata (rd[k])
        );
    end

    // Lane 0 is the oldest row; lanes above the frame's first line are masked.
    always_comb begin
        lanes   = '0;
        ref_pix = '0;
        raw[LINE_NUM-1] = in_data;
        for (int j = 0; j < LINE_NUM - 1; j++) begin
            raw[j] = rd[LINE_NUM-2-j];
        end
        for (int j = 0; j < LINE_NUM; j++) begin
            if (int'(cur_row) == LINE_NUM - 1 - j) begin
                ref_pix = raw[j];
            end
        end
        for (int j = 0; j < LINE_NUM; j++) begin
            if (int'(cur_row) >= LINE_NUM - 1 - j) begin
                lanes[j*DATA_WIDTH +: DATA_WIDTH] = raw[j];
            end else if (cur_mode == MODE_REPLICATE) begin
                lanes[j*DATA_WIDTH +: DATA_WIDTH] = ref_pix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_data  <= '0;
            width_q   <= clamp_w(cfg_width);
            mode_q    <= mode_e'(cfg_mode);
            sof_pend  <= 1'b1;
        end else if (accept) begin
            col     <= col_nxt;
            row     <= row_nxt;
            width_q <= cur_width;
            mode_q  <= cur_mode;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= lanes;
                out_sof   <= in_sof | sof_pend;
                out_eol   <= eol;
                sof_pend  <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                sof_pend  <= in_sof | sof_pend;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_align.sv
// Bench for line_window_align: directed scenarios plus a random stream
// scored against a frame-level model of column windows.
module tb_line_window_align;

    localparam int DW = 8;
    localparam int LN = 3;
    localparam int MW = 16;
    localparam int WB = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [WB-1:0]    cfg_width;
    logic [1:0]       cfg_mode;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [DW*LN-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eol;
    logic             window_full;

    line_window_align #(
        .DATA_WIDTH (DW),
        .LINE_NUM   (LN),
        .MAX_WIDTH  (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_width   (cfg_width),
        .cfg_mode    (cfg_mode),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .window_full (window_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*LN-1:0] d;
        logic             s;
        logic             e;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t hold_b;
    bit    hold_prev;
    int    checks;
    int    failures;

    // Model: frame-relative line number (unbounded) and a pixel store.
    int m_width, m_mode, m_line, m_col;
    bit m_sofp;
    int pix [64][16];

    function automatic logic [DW*LN-1:0] pack3(input int a0, input int a1, input int a2);
        logic [DW-1:0] x0, x1, x2;
        x0 = a0[DW-1:0];
        x1 = a1[DW-1:0];
        x2 = a2[DW-1:0];
        return {x2, x1, x0};
    endfunction

    function automatic int clampw(input int w);
        return (w == 0 || w > MW) ? MW : w;
    endfunction

    task automatic model_reset(input int cw, input int cm);
        m_width = clampw(cw);
        m_mode  = cm;
        m_line  = 0;
        m_col   = 0;
        m_sofp  = 1'b1;
    endtask

    task automatic model_accept(input int d, input bit s, input int cw, input int cm);
        beat_t b;
        int    src;
        int    v;
        if (s) begin
            model_reset(cw, cm);
        end
        pix[m_line % 64][m_col] = d;
        if (m_mode == 1 || m_mode == 2 || m_line >= LN - 1) begin
            b.d = '0;
            for (int j = 0; j < LN; j++) begin
                src = m_line - (LN - 1 - j);
                if (src >= 0) v = pix[src % 64][m_col];
                else if (m_mode == 2) v = pix[0][m_col];
                else v = 0;
                b.d[j*DW +: DW] = v[DW-1:0];
            end
            b.s = m_sofp;
            b.e = (m_col == m_width - 1);
            exp_q.push_back(b);
            m_sofp = 1'b0;
        end
        m_col++;
        if (m_col == m_width) begin
            m_col = 0;
            m_line++;
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit s, input bit r,
                         input int cw, input int cm);
        beat_t b;
        @(negedge clk);
        in_valid  = v;
        in_data   = d[DW-1:0];
        in_sof    = s;
        out_ready = r;
        cfg_width = cw[WB-1:0];
        cfg_mode  = cm[1:0];
        #1;
        if (hold_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_b.d
                || out_sof !== hold_b.s || out_eol !== hold_b.e) begin
                failures++;
                $display("FAIL hold_stable: valid=%b data=%h sof=%b eol=%b, required 1 %h %b %b",
                         out_valid, out_data, out_sof, out_eol, hold_b.d, hold_b.s, hold_b.e);
            end
        end
        checks++;
        if (window_full !== (m_line >= LN - 1)) begin
            failures++;
            $display("FAIL window_full: got %b required %b", window_full, m_line >= LN - 1);
        end
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
            failures++;
            $display("FAIL in_ready: got %b required %b", in_ready, !out_valid || out_ready);
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: data=%h, required no output", out_data);
            end else begin
                b = exp_q.pop_front();
                if (out_data !== b.d || out_sof !== b.s || out_eol !== b.e) begin
                    failures++;
                    $display("FAIL output: data=%h sof=%b eol=%b, required %h %b %b",
                             out_data, out_sof, out_eol, b.d, b.s, b.e);
                end
            end
            got_q.push_back('{out_data, out_sof, out_eol});
        end
        hold_prev = out_valid && !out_ready;
        hold_b    = '{out_data, out_sof, out_eol};
        if (v && in_ready) begin
            model_accept(d, s, cw, cm);
        end
    endtask

    task automatic do_reset(input int cw, input int cm);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        cfg_width = cw[WB-1:0];
        cfg_mode  = cm[1:0];
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_sof, out_eol, window_full} !== 4'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b sof=%b eol=%b full=%b data=%h, required all 0",
                     out_valid, out_sof, out_eol, window_full, out_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        rst = 1'b0;
        model_reset(cw, cm);
        exp_q.delete();
        hold_prev = 1'b0;
    endtask

    task automatic send_frame(input int cm);
        for (int i = 1; i <= 12; i++) cycle(1'b1, i, i == 1, 1'b1, 4, cm);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1, 4, cm);
    endtask

    task automatic check_mode0_seq(input string tag);
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL %s_count: got %0d required 4", tag, got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i].d !== pack3(i + 1, i + 5, i + 9)
                    || got_q[i].s !== (i == 0) || got_q[i].e !== (i == 3)) begin
                    failures++;
                    $display("FAIL %s_beat%0d: data=%h sof=%b eol=%b, required %h %b %b", tag, i,
                             got_q[i].d, got_q[i].s, got_q[i].e,
                             pack3(i + 1, i + 5, i + 9), i == 0, i == 3);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(4, 0);
    endtask

    task automatic test_mode0();
        got_q.delete();
        send_frame(0);
        check_mode0_seq("mode0");
    endtask

    task automatic test_mode2();
        got_q.delete();
        send_frame(2);
        checks++;
        if (got_q.size() != 12) begin
            failures++;
            $display("FAIL mode2_count: got %0d required 12", got_q.size());
        end else begin
            checks++;
            if (got_q[0].d !== pack3(1, 1, 1) || got_q[0].s !== 1'b1) begin
                failures++;
                $display("FAIL mode2_first: data=%h sof=%b required %h 1", got_q[0].d, got_q[0].s, pack3(1, 1, 1));
            end
            checks++;
            if (got_q[4].d !== pack3(1, 1, 5)) begin
                failures++;
                $display("FAIL mode2_fifth: data=%h required %h", got_q[4].d, pack3(1, 1, 5));
            end
            checks++;
            if (got_q[8].d !== pack3(1, 5, 9)) begin
                failures++;
                $display("FAIL mode2_ninth: data=%h required %h", got_q[8].d, pack3(1, 5, 9));
            end
        end
    endtask

    task automatic test_mode1();
        got_q.delete();
        send_frame(1);
        checks++;
        if (got_q.size() != 12) begin
            failures++;
            $display("FAIL mode1_count: got %0d required 12", got_q.size());
        end else begin
            checks++;
            if (got_q[0].d !== pack3(0, 0, 1)) begin
                failures++;
                $display("FAIL mode1_first: data=%h required %h", got_q[0].d, pack3(0, 0, 1));
            end
            checks++;
            if (got_q[5].d !== pack3(0, 2, 6)) begin
                failures++;
                $display("FAIL mode1_sixth: data=%h required %h", got_q[5].d, pack3(0, 2, 6));
            end
        end
    endtask

    task automatic test_stall();
        got_q.delete();
        for (int i = 1; i <= 10; i++) cycle(1'b1, i, i == 1, 1'b1, 4, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 11, 1'b0, 1'b0, 4, 0);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready: cycle %0d got %b required 0", k, in_ready);
            end
        end
        for (int i = 11; i <= 12; i++) cycle(1'b1, i, 1'b0, 1'b1, 4, 0);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1, 4, 0);
        check_mode0_seq("stall");
    endtask

    task automatic test_midframe_sof();
        got_q.delete();
        for (int i = 1; i <= 5; i++) cycle(1'b1, i, i == 1, 1'b1, 4, 0);
        for (int k = 0; k <= 32; k++) cycle(1'b1, 6 + k, k == 0, 1'b1, 0, 0);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL midsof_early: got %0d outputs required 0", got_q.size());
        end
        for (int k = 33; k < 48; k++) cycle(1'b1, 6 + k, 1'b0, 1'b1, 0, 0);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1, 0, 0);
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("FAIL midsof_count: got %0d required 16", got_q.size());
        end else begin
            checks++;
            if (got_q[0].d !== pack3(6, 22, 38) || got_q[0].s !== 1'b1 || got_q[0].e !== 1'b0) begin
                failures++;
                $display("FAIL midsof_first: data=%h sof=%b eol=%b required %h 1 0",
                         got_q[0].d, got_q[0].s, got_q[0].e, pack3(6, 22, 38));
            end
            checks++;
            if (got_q[14].e !== 1'b0 || got_q[15].e !== 1'b1 || got_q[15].d !== pack3(21, 37, 53)) begin
                failures++;
                $display("FAIL midsof_last: data=%h eol14=%b eol15=%b required %h 0 1",
                         got_q[15].d, got_q[14].e, got_q[15].e, pack3(21, 37, 53));
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 1; i <= 10; i++) cycle(1'b1, i, i == 1, 1'b1, 4, 0);
        do_reset(4, 0);
        got_q.delete();
        send_frame(0);
        check_mode0_seq("rstmid");
    endtask

    task automatic test_random();
        bit v, s, r;
        int cw, cm, d;
        for (int n = 0; n < 3000; n++) begin
            cw = $urandom_range(0, 31);
            cm = $urandom_range(0, 3);
            d  = $urandom_range(0, 255);
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 7);
            s  = (n == 0) || ($urandom_range(0, 39) == 0);
            cycle(v | (n == 0), d, s, r, cw, cm);
        end
        repeat (4) cycle(1'b0, 0, 1'b0, 1'b1, 4, 0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain: %0d outputs missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        cfg_width = 5'd4;
        cfg_mode  = 2'd0;
        checks    = 0;
        failures  = 0;
        hold_prev = 1'b0;
        model_reset(4, 0);
        test_reset();
        test_mode0();
        test_mode2();
        test_mode1();
        test_stall();
        test_midframe_sof();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
